// File: rtl/clock_gated_approx_mult_pipe.sv
// Two-stage unsigned multiplier (exact or truncated-approximate) whose operand and
// result banks are clocked only on load through latch-based clock gates.
module clock_gated_approx_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               approx,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Y,
  output logic [CNT_W-1:0]   gate_cnt
);

  logic               v_a;
  logic               v_b;
  logic               ld_b;
  logic               accept;
  logic               en_lat_a;
  logic               en_lat_b;
  logic               gclk_a;
  logic               gclk_b;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_mode;
  logic [2*WIDTH-1:0] prod_exact;
  logic [2*WIDTH-1:0] prod_apx;

  assign ld_b      = en & v_a & (~v_b | out_ready);
  assign in_ready  = rst & en & (~v_a | ld_b);
  assign accept    = in_valid & in_ready;
  assign out_valid = en & v_b;

  // Enables are captured while clk is low so the gated clocks cannot glitch.
  always_latch begin
    if (!clk) begin
      en_lat_a <= accept;
      en_lat_b <= ld_b;
    end
  end

  assign gclk_a = clk & en_lat_a;
  assign gclk_b = clk & en_lat_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_a      <= 1'b0;
      v_b      <= 1'b0;
      gate_cnt <= '0;
    end else begin
      if (accept)
        v_a <= 1'b1;
      else if (ld_b)
        v_a <= 1'b0;

      if (ld_b)
        v_b <= 1'b1;
      else if (out_valid && out_ready)
        v_b <= 1'b0;

      if (!ld_b && gate_cnt != {CNT_W{1'b1}})
        gate_cnt <= gate_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge gclk_a or negedge rst) begin
    if (!rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_mode <= 1'b0;
    end else begin
      op_a    <= A;
      op_b    <= B;
      op_mode <= approx;
    end
  end

  assign prod_exact = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

  // Truncated product keeps only partial-product bits of weight 2^TRUNC and above.
  always_comb begin
    prod_apx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j >= TRUNC)
          prod_apx = prod_apx + ((2*WIDTH)'(op_a[i] & op_b[j]) << (i + j));
      end
    end
  end

  always_ff @(posedge gclk_b or negedge rst) begin
    if (!rst)
      Y <= '0;
    else
      Y <= op_mode ? prod_apx : prod_exact;
  end

endmodule
